// File: rtl/sevenseg_count_ctrl.sv
// Prescaled up/down single-digit counter with registered seven-segment outputs and a run LED.
// Define SEVENSEG_HEX_EN to count 0..F with hex glyphs; by default the digit is decimal 0..9.
module sevenseg_count_ctrl #(
    parameter int TICK_DIV       = 20000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       up,
    output logic [3:0] value,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       wrap,
    output logic       run_led
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
`ifdef SEVENSEG_HEX_EN
    localparam logic [3:0]    MAXV      = 4'd15;
`else
    localparam logic [3:0]    MAXV      = 4'd9;
`endif

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [3:0]    load_clamped;
    logic [6:0]    seg_q;

    assign tick    = (state == RUN) && (prescaler == TICK_LAST);
    assign run_led = (state == RUN);

`ifdef SEVENSEG_HEX_EN
    assign load_clamped = load_val;
`else
    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;
`endif

    // Priority chain: clear > load > stop > start > tick. A stop in IDLE still
    // outranks start; start while already running is a no-op so counting continues.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            value     <= '0;
            prescaler <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                value     <= '0;
                prescaler <= '0;
            end else if (load) begin
                value     <= load_clamped;
                prescaler <= '0;
            end else if (stop) begin
                if (state == RUN) begin
                    state <= PAUSE;
                end else if (state == PAUSE) begin
                    state <= IDLE;
                end
            end else if (start && (state != RUN)) begin
                if (state == IDLE) begin
                    prescaler <= '0;
                end
                state <= RUN;
            end else if (state == RUN) begin
                if (tick) begin
                    prescaler <= '0;
                    if (up) begin
                        if (value == MAXV) begin
                            value <= '0;
                            wrap  <= 1'b1;
                        end else begin
                            value <= value + 4'd1;
                        end
                    end else begin
                        if (value == 4'd0) begin
                            value <= MAXV;
                            wrap  <= 1'b1;
                        end else begin
                            value <= value - 4'd1;
                        end
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    // Active-high glyphs, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b1111110;
            4'd1:    glyph = 7'b0110000;
            4'd2:    glyph = 7'b1101101;
            4'd3:    glyph = 7'b1111001;
            4'd4:    glyph = 7'b0110011;
            4'd5:    glyph = 7'b1011011;
            4'd6:    glyph = 7'b1011111;
            4'd7:    glyph = 7'b1110000;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1111011;
`ifdef SEVENSEG_HEX_EN
            4'd10:   glyph = 7'b1110111;
            4'd11:   glyph = 7'b0011111;
            4'd12:   glyph = 7'b1001110;
            4'd13:   glyph = 7'b0111101;
            4'd14:   glyph = 7'b1001111;
            4'd15:   glyph = 7'b1000111;
`endif
            default: glyph = 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        seg_q <= SEG_ACTIVE_LOW ? ~glyph(value) : glyph(value);
    end

    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_sevenseg_count_ctrl.sv
// Scoreboard bench for sevenseg_count_ctrl (TICK_DIV=4, SEG_ACTIVE_LOW=1); directed vectors.
module tb_sevenseg_count_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, clear, load, up;
    logic [3:0] load_val;
    logic [3:0] value;
    logic       a, b, c, d, e, f, g, wrap, run_led;

    typedef struct packed {
        logic [3:0] value;
        logic       wrap;
        logic       runLed;
        logic [6:0] segs;
    } expect_t;

    expect_t expQ[$];
    string   nameQ[$];
    int      checks = 0;
    int      errors = 0;
    int      lastExpValue = 0;

`ifdef SEVENSEG_HEX_EN
    localparam int MAXV   = 15;
    localparam int LOAD12 = 12;
`else
    localparam int MAXV   = 9;
    localparam int LOAD12 = 9;
`endif

    sevenseg_count_ctrl #(.TICK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load(load), .load_val(load_val), .up(up), .value(value),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .wrap(wrap), .run_led(run_led)
    );

    always #5 clk = ~clk;

    // Active-low expected pin patterns {a..g}.
    function automatic logic [6:0] segOf(input int v);
        case (v)
            0:       segOf = 7'b0000001;
            1:       segOf = 7'b1001111;
            2:       segOf = 7'b0010010;
            3:       segOf = 7'b0000110;
            4:       segOf = 7'b1001100;
            5:       segOf = 7'b0100100;
            6:       segOf = 7'b0100000;
            7:       segOf = 7'b0001111;
            8:       segOf = 7'b0000000;
            9:       segOf = 7'b0000100;
            10:      segOf = 7'b0001000;
            11:      segOf = 7'b1100000;
            12:      segOf = 7'b0110001;
            13:      segOf = 7'b1000010;
            14:      segOf = 7'b0110000;
            15:      segOf = 7'b0111000;
            default: segOf = 7'b1111111;
        endcase
    endfunction

    task automatic applyStimulus(input logic r, input logic st, input logic sp, input logic cl,
                                 input logic ld, input logic [3:0] lv, input logic u);
        @(negedge clk);
        rst = r; start = st; stop = sp; clear = cl; load = ld; load_val = lv; up = u;
        @(posedge clk);
        #1;
    endtask

    // Segments trail the digit by one cycle, so they are expected to show the previous value.
    task automatic checkOutput(input string name, input int v, input logic w, input logic rl);
        expect_t x;
        x.value  = 4'(v);
        x.wrap   = w;
        x.runLed = rl;
        x.segs   = segOf(lastExpValue);
        expQ.push_back(x);
        nameQ.push_back(name);
        lastExpValue = v;
    endtask

    task automatic cyc(input string name, input logic r, input logic st, input logic sp,
                       input logic cl, input logic ld, input logic [3:0] lv, input logic u,
                       input int v, input logic w, input logic rl);
        applyStimulus(r, st, sp, cl, ld, lv, u);
        checkOutput(name, v, w, rl);
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            expect_t x;
            string   nm;
            x  = expQ.pop_front();
            nm = nameQ.pop_front();
            checks++;
            if (value !== x.value || wrap !== x.wrap || run_led !== x.runLed ||
                {a, b, c, d, e, f, g} !== x.segs) begin
                errors++;
                $display("[TB] FAIL %s: got value=%0d wrap=%0b run_led=%0b segs=%07b, expected value=%0d wrap=%0b run_led=%0b segs=%07b",
                         nm, value, wrap, run_led, {a, b, c, d, e, f, g},
                         x.value, x.wrap, x.runLed, x.segs);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int v;
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        load_val = 4'd0; up = 1'b1;

        applyStimulus(1, 0, 0, 0, 0, 4'd0, 1);
        cyc("reset", 1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);

        // Count up from 0 for 40 cycles.
        cyc("start", 0, 1, 0, 0, 0, 4'd0, 1, 0, 0, 1);
        for (int n = 1; n <= 40; n++)
            cyc("count_up", 0, 0, 0, 0, 0, 4'd0, 1, (n / 4) % (MAXV + 1),
                (n % 4 == 0) && ((n / 4) % (MAXV + 1) == 0), 1);
        v = 10 % (MAXV + 1);

        // Stop on the tick cycle, then resume one cycle later.
        for (int n = 0; n < 3; n++) cyc("pre_stop", 0, 0, 0, 0, 0, 4'd0, 1, v, 0, 1);
        cyc("stop_on_tick", 0, 0, 1, 0, 0, 4'd0, 1, v, 0, 0);
        cyc("resume", 0, 1, 0, 0, 0, 4'd0, 1, v, 0, 1);
        v = (v + 1) % (MAXV + 1);
        cyc("step_after_resume", 0, 0, 0, 0, 0, 4'd0, 1, v, v == 0, 1);

        // PAUSE then IDLE with value retained; restart clears the prescaler.
        cyc("run", 0, 0, 0, 0, 0, 4'd0, 1, v, 0, 1);
        cyc("pause", 0, 0, 1, 0, 0, 4'd0, 1, v, 0, 0);
        cyc("to_idle", 0, 0, 1, 0, 0, 4'd0, 1, v, 0, 0);
        for (int n = 0; n < 2; n++) cyc("idle_hold", 0, 0, 0, 0, 0, 4'd0, 1, v, 0, 0);
        cyc("restart", 0, 1, 0, 0, 0, 4'd0, 1, v, 0, 1);
        for (int n = 0; n < 3; n++) cyc("prescaler_cleared", 0, 0, 0, 0, 0, 4'd0, 1, v, 0, 1);
        v = (v + 1) % (MAXV + 1);
        cyc("restart_step", 0, 0, 0, 0, 0, 4'd0, 1, v, v == 0, 1);

        // Load of 12 (clamped in decimal build), then tick coinciding with load.
        cyc("load12", 0, 0, 0, 0, 1, 4'd12, 1, LOAD12, 0, 1);
        for (int n = 0; n < 3; n++) cyc("load12_hold", 0, 0, 0, 0, 0, 4'd0, 1, LOAD12, 0, 1);
        v = (LOAD12 + 1) % (MAXV + 1);
        cyc("load12_step", 0, 0, 0, 0, 0, 4'd0, 1, v, v == 0, 1);
        for (int n = 0; n < 3; n++) cyc("pre_load_tick", 0, 0, 0, 0, 0, 4'd0, 1, v, 0, 1);
        cyc("tick_vs_load", 0, 0, 0, 0, 1, 4'd5, 1, 5, 0, 1);

        // Count down through zero.
        cyc("load_zero", 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        for (int n = 0; n < 3; n++) cyc("down_hold", 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1);
        cyc("down_wrap", 0, 0, 0, 0, 0, 4'd0, 0, MAXV, 1, 1);
        for (int n = 0; n < 3; n++) cyc("down_wrap_hold", 0, 0, 0, 0, 0, 4'd0, 0, MAXV, 0, 1);
        cyc("down_step", 0, 0, 0, 0, 0, 4'd0, 0, MAXV - 1, 0, 1);

        // Clear beats load; clear beats tick.
        cyc("clear_and_load", 0, 0, 0, 1, 1, 4'd7, 1, 0, 0, 0);
        for (int n = 0; n < 2; n++) cyc("idle_no_count", 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        cyc("start_after_clear", 0, 1, 0, 0, 0, 4'd0, 1, 0, 0, 1);
        for (int n = 0; n < 3; n++) cyc("clear_hold", 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 1);
        cyc("clear_step", 0, 0, 0, 0, 0, 4'd0, 1, 1, 0, 1);
        for (int n = 0; n < 3; n++) cyc("pre_clear_tick", 0, 0, 0, 0, 0, 4'd0, 1, 1, 0, 1);
        cyc("tick_vs_clear", 0, 0, 0, 1, 0, 4'd0, 1, 0, 0, 0);

        // Load in IDLE: clamped in decimal build, state stays IDLE.
        cyc("load_idle", 0, 0, 0, 0, 1, 4'd15, 1, MAXV, 0, 0);
        cyc("load_idle_hold", 0, 0, 0, 0, 0, 4'd0, 1, MAXV, 0, 0);

        // Reset mid-count at 5.
        cyc("load5", 0, 0, 0, 0, 1, 4'd5, 1, 5, 0, 0);
        cyc("start5", 0, 1, 0, 0, 0, 4'd0, 1, 5, 0, 1);
        for (int n = 0; n < 2; n++) cyc("hold5", 0, 0, 0, 0, 0, 4'd0, 1, 5, 0, 1);
        cyc("reset_mid", 1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        cyc("after_reset", 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);

        // Reset on a wrapping tick: no wrap pulse.
        cyc("load_max", 0, 0, 0, 0, 1, 4'(MAXV), 1, MAXV, 0, 0);
        cyc("start_max", 0, 1, 0, 0, 0, 4'd0, 1, MAXV, 0, 1);
        for (int n = 0; n < 3; n++) cyc("hold_max", 0, 0, 0, 0, 0, 4'd0, 1, MAXV, 0, 1);
        cyc("reset_on_wrap", 1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        cyc("no_late_wrap", 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);

        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
